// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline control unit of the three-stage core.
//   state_t      : halt state machine encoding (RUN/DRAIN/HALTED/RESUME)
//   NOP_INST     : bubble instruction loaded by a flushed stage
//   ZERO_REG     : architectural x0, never a real hazard source
//   DRAIN_CNT_W  : width of the drain down-counter (DRAIN_CYCLES up to 15)
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2,
        RESUME = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INST    = 32'h0000_0013;
    localparam logic [4:0]  ZERO_REG    = 5'd0;
    localparam int          DRAIN_CNT_W = 4;

endpackage

// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if
// Bundles the hazard/redirect inputs and the per-stage control outputs of
// pipe_ctrl.
//   modport slave  : pipe_ctrl side (consumes *_i, produces *_o)
//   modport master : core / testbench side (produces *_i, consumes *_o)
// -----------------------------------------------------------------------------
interface pipe_ctrl_if;

    // Requests from ex / id / debug
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        ex_busy_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic        id_rs1_used_i;
    logic        id_rs2_used_i;
    logic [4:0]  id_ex_rd_addr_i;
    logic        id_ex_is_load_i;
    logic        halt_req_i;

    // Controls to pc_reg / if_id / id_ex and status
    logic        pc_jump_en_o;
    logic [31:0] pc_jump_addr_o;
    logic        pc_hold_o;
    logic        if_id_hold_o;
    logic        id_ex_hold_o;
    logic        if_id_flush_o;
    logic        id_ex_flush_o;
    logic        halt_ack_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;

    modport slave (
        input  jump_en_i, jump_addr_i, ex_busy_i,
               id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
               id_ex_rd_addr_i, id_ex_is_load_i, halt_req_i,
        output pc_jump_en_o, pc_jump_addr_o, pc_hold_o, if_id_hold_o,
               id_ex_hold_o, if_id_flush_o, id_ex_flush_o, halt_ack_o,
               stall_cnt_o, flush_cnt_o
    );

    modport master (
        output jump_en_i, jump_addr_i, ex_busy_i,
               id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
               id_ex_rd_addr_i, id_ex_is_load_i, halt_req_i,
        input  pc_jump_en_o, pc_jump_addr_o, pc_hold_o, if_id_hold_o,
               id_ex_hold_o, if_id_flush_o, id_ex_flush_o, halt_ack_o,
               stall_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/pipe_ctrl_hazard.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_hazard
// Purely combinational load-use detector. Flags the case where the id
// instruction reads a register that the load currently in id_ex will write,
// so the consumer must wait one cycle for the load data.
//   rs1_addr, rs2_addr : id source registers
//   rs1_used, rs2_used : id instruction actually reads that source
//   rd_addr            : id_ex destination register
//   is_load            : id_ex instruction is a load
//   hazard             : load-use hazard this cycle
// -----------------------------------------------------------------------------
module pipe_ctrl_hazard
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    input  logic       rs1_used,
    input  logic       rs2_used,
    input  logic [4:0] rd_addr,
    input  logic       is_load,
    output logic       hazard
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = rs1_used && (rs1_addr == rd_addr);
    assign rs2_match = rs2_used && (rs2_addr == rd_addr);

    // x0 writes are discarded, so a load to x0 never produces a dependency.
    assign hazard = is_load && (rd_addr != ZERO_REG) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline control unit for the pc_reg -> if_id -> id_ex -> ex core. Resolves
// redirect, ex-busy, debug-halt and load-use conditions into per-stage hold /
// flush controls and the PC redirect, and runs the debug-halt state machine
// (RUN -> DRAIN -> HALTED -> RESUME -> RUN).
//   clk  : core clock
//   rst  : synchronous, active-high reset
//   bus  : pipe_ctrl_if.slave (requests in, stage controls / status out)
// Parameter DRAIN_CYCLES (1..15): cycles spent in DRAIN before HALTED.
// Optional feature macro PIPE_CTRL_PERF_EN: enables the stall/flush
// performance counters; without it both counter outputs are tied to 0.
// -----------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 1
)(
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus
);

    state_t                 state, state_next;
    logic [DRAIN_CNT_W-1:0] drain_cnt, drain_cnt_next;
    logic                   halt_ack;
    logic                   hazard;

    logic                   pc_jump_en;
    logic [31:0]            pc_jump_addr;
    logic                   pc_hold;
    logic                   if_id_hold;
    logic                   id_ex_hold;
    logic                   if_id_flush;
    logic                   id_ex_flush;

    pipe_ctrl_hazard u_hazard (
        .rs1_addr (bus.id_rs1_addr_i),
        .rs2_addr (bus.id_rs2_addr_i),
        .rs1_used (bus.id_rs1_used_i),
        .rs2_used (bus.id_rs2_used_i),
        .rd_addr  (bus.id_ex_rd_addr_i),
        .is_load  (bus.id_ex_is_load_i),
        .hazard   (hazard)
    );

    // ---------------------------------------------------------------------
    // Halt FSM: next state and drain counter
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_next     = state;
        drain_cnt_next = drain_cnt;
        unique case (state)
            RUN: begin
                if (bus.halt_req_i) begin
                    state_next     = DRAIN;
                    drain_cnt_next = DRAIN_CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            DRAIN: begin
                // A frozen pipeline (ex busy, not overridden by a redirect)
                // makes no drain progress; a redirect lets the drain proceed.
                if (!(bus.ex_busy_i && !bus.jump_en_i)) begin
                    if (drain_cnt == '0) begin
                        state_next = HALTED;
                    end else begin
                        drain_cnt_next = drain_cnt - 1'b1;
                    end
                end
            end
            HALTED: begin
                if (!bus.halt_req_i) begin
                    state_next = RESUME;
                end
            end
            RESUME: begin
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (rst) begin
            state     <= RUN;
            drain_cnt <= '0;
            halt_ack  <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
            // Registered acknowledge: high exactly while the FSM sits in HALTED.
            halt_ack  <= (state_next == HALTED);
        end
    end

    // ---------------------------------------------------------------------
    // Priority mux: redirect > ex busy > drain/halted > load-use > idle
    // ---------------------------------------------------------------------
    always_comb begin
        pc_jump_en   = 1'b0;
        pc_jump_addr = '0;
        pc_hold      = 1'b0;
        if_id_hold   = 1'b0;
        id_ex_hold   = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        if (!rst) begin
            if (bus.jump_en_i) begin
                pc_jump_en   = 1'b1;
                pc_jump_addr = bus.jump_addr_i;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
            end else if (bus.ex_busy_i) begin
                pc_hold    = 1'b1;
                if_id_hold = 1'b1;
                id_ex_hold = 1'b1;
            end else if (state == DRAIN || state == HALTED) begin
                // Keep the id instruction, let ex finish, feed bubbles behind it.
                pc_hold     = 1'b1;
                if_id_hold  = 1'b1;
                id_ex_flush = 1'b1;
            end else if (hazard) begin
                pc_hold     = 1'b1;
                if_id_hold  = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    assign bus.pc_jump_en_o   = pc_jump_en;
    assign bus.pc_jump_addr_o = pc_jump_addr;
    assign bus.pc_hold_o      = pc_hold;
    assign bus.if_id_hold_o   = if_id_hold;
    assign bus.id_ex_hold_o   = id_ex_hold;
    assign bus.if_id_flush_o  = if_id_flush;
    assign bus.id_ex_flush_o  = id_ex_flush;
    assign bus.halt_ack_o     = halt_ack;

    // ---------------------------------------------------------------------
    // Optional performance counters (wrap naturally at 32 bits)
    // ---------------------------------------------------------------------
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_hold) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (if_id_flush || id_ex_flush) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign bus.stall_cnt_o = stall_cnt;
    assign bus.flush_cnt_o = flush_cnt;
`else
    assign bus.stall_cnt_o = '0;
    assign bus.flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl (DRAIN_CYCLES=1). Combinational vectors in
// RUN come from a table; halt, drain and reset corner cases are hand-written
// cycle sequences. Each cycle's expected controls are queued when the inputs
// are driven and compared when the outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.DRAIN_CYCLES(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        jump_en;
        logic [31:0] jump_addr;
        logic        ex_busy;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rs1_used;
        logic        rs2_used;
        logic [4:0]  rd;
        logic        is_load;
        logic        halt_req;
    } in_t;

    typedef struct {
        in_t         in;
        logic [6:0]  ctrl;
        logic [31:0] addr;
    } vec_t;

    // ctrl = {pc_jump_en, pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush, halt_ack}
    localparam logic [6:0] C_NONE  = 7'b000_0000;
    localparam logic [6:0] C_STALL = 7'b011_0010;
    localparam logic [6:0] C_BUSY  = 7'b011_1000;
    localparam logic [6:0] C_JUMP  = 7'b100_0110;
    localparam logic [6:0] C_HALT  = 7'b011_0011;
    localparam logic [6:0] C_ACK   = 7'b000_0001;

    int checks   = 0;
    int failures = 0;

    logic [38:0] exp_q[$];
    longint      stall_model = 0;
    longint      flush_model = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic in_t mk(input logic jump_en, input logic [31:0] jump_addr,
                               input logic ex_busy, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic rs1_used,
                               input logic rs2_used, input logic [4:0] rd,
                               input logic is_load, input logic halt_req);
        in_t r;
        r.jump_en   = jump_en;
        r.jump_addr = jump_addr;
        r.ex_busy   = ex_busy;
        r.rs1       = rs1;
        r.rs2       = rs2;
        r.rs1_used  = rs1_used;
        r.rs2_used  = rs2_used;
        r.rd        = rd;
        r.is_load   = is_load;
        r.halt_req  = halt_req;
        return r;
    endfunction

    task automatic apply(input in_t in);
        bus.jump_en_i       = in.jump_en;
        bus.jump_addr_i     = in.jump_addr;
        bus.ex_busy_i       = in.ex_busy;
        bus.id_rs1_addr_i   = in.rs1;
        bus.id_rs2_addr_i   = in.rs2;
        bus.id_rs1_used_i   = in.rs1_used;
        bus.id_rs2_used_i   = in.rs2_used;
        bus.id_ex_rd_addr_i = in.rd;
        bus.id_ex_is_load_i = in.is_load;
        bus.halt_req_i      = in.halt_req;
    endtask

    // One clock cycle: drive, queue expectation, sample on falling edge, compare.
    task automatic step(input string name, input in_t in, input logic [6:0] ctrl, input logic [31:0] addr);
        logic [38:0] e;
        logic [6:0]  act;
        apply(in);
        exp_q.push_back({ctrl, addr});
        @(negedge clk);
        e   = exp_q.pop_front();
        act = {bus.pc_jump_en_o, bus.pc_hold_o, bus.if_id_hold_o, bus.id_ex_hold_o,
               bus.if_id_flush_o, bus.id_ex_flush_o, bus.halt_ack_o};
        check({name, " ctrl"}, {25'd0, act}, {25'd0, e[38:32]});
        check({name, " addr"}, bus.pc_jump_addr_o, e[31:0]);
        check({name, " excl"}, {31'd0, (bus.if_id_hold_o & bus.if_id_flush_o) |
                                       (bus.id_ex_hold_o & bus.id_ex_flush_o)}, 32'd0);
        if (rst) begin
            stall_model = 0;
            flush_model = 0;
        end else begin
            stall_model += ctrl[5];
            flush_model += (ctrl[2] | ctrl[1]);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[9];

    initial begin
        in_t idle, hz, hlt;
        idle = mk(0, 32'h0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
        hz   = mk(0, 32'h0, 0, 5'd5, 5'd7, 1, 0, 5'd5, 1, 0);
        hlt  = idle;
        hlt.halt_req = 1'b1;

        // Combinational behaviour in RUN.
        tbl[0] = '{mk(0, 32'h0,        0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0), C_NONE,  32'h0};
        tbl[1] = '{mk(0, 32'h0,        0, 5'd5, 5'd7, 1, 0, 5'd5, 1, 0), C_STALL, 32'h0};
        tbl[2] = '{mk(0, 32'h0,        0, 5'd0, 5'd7, 1, 0, 5'd0, 1, 0), C_NONE,  32'h0};
        tbl[3] = '{mk(0, 32'h0,        0, 5'd5, 5'd7, 0, 1, 5'd5, 1, 0), C_NONE,  32'h0};
        tbl[4] = '{mk(0, 32'h0,        0, 5'd3, 5'd9, 0, 1, 5'd9, 1, 0), C_STALL, 32'h0};
        tbl[5] = '{mk(0, 32'h0,        0, 5'd5, 5'd5, 1, 1, 5'd5, 0, 0), C_NONE,  32'h0};
        tbl[6] = '{mk(1, 32'h100,      0, 5'd5, 5'd7, 1, 0, 5'd5, 1, 0), C_JUMP,  32'h100};
        tbl[7] = '{mk(0, 32'hDEADBEEF, 0, 5'd1, 5'd2, 1, 1, 5'd4, 1, 0), C_NONE,  32'h0};
        tbl[8] = '{mk(1, 32'h40,       1, 5'd5, 5'd7, 1, 0, 5'd5, 1, 0), C_JUMP,  32'h40};

        apply(idle);
        repeat (2) @(posedge clk);
        #1;
        step("reset_forced", mk(1, 32'h1234, 1, 5'd5, 5'd5, 1, 1, 5'd5, 1, 1), C_NONE, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            step($sformatf("vec%0d", i), tbl[i].in, tbl[i].ctrl, tbl[i].addr);
        end

        // Load-use lasts only while it is present.
        step("lu_on", hz, C_STALL, 32'h0);
        step("lu_off", idle, C_NONE, 32'h0);

        // ex busy for 4 cycles, with a hazard underneath.
        hz.ex_busy = 1'b1;
        for (int i = 0; i < 4; i++) step($sformatf("busy%0d", i), hz, C_BUSY, 32'h0);
        hz.ex_busy = 1'b0;
        step("busy_end", idle, C_NONE, 32'h0);

        // Halt pulse: RUN(req) -> DRAIN -> HALTED -> RESUME -> RUN.
        step("hp_run", hlt, C_NONE, 32'h0);
        step("hp_drain", idle, C_STALL, 32'h0);
        step("hp_halted", idle, C_HALT, 32'h0);
        step("hp_resume", idle, C_NONE, 32'h0);
        step("hp_run2", idle, C_NONE, 32'h0);

        // Held request, hazard ignored in HALTED, honoured in RESUME.
        hz.halt_req = 1'b1;
        step("hh_run", hlt, C_NONE, 32'h0);
        step("hh_drain", hlt, C_STALL, 32'h0);
        step("hh_halted", hlt, C_HALT, 32'h0);
        step("hh_halted_hz", hz, C_HALT, 32'h0);
        step("hh_halted_last", idle, C_HALT, 32'h0);
        hz.halt_req = 1'b0;
        step("hh_resume_hz", hz, C_STALL, 32'h0);

        // Jump during DRAIN wins outputs; HALTED still on schedule.
        step("jd_run", hlt, C_NONE, 32'h0);
        step("jd_drain_jump", mk(1, 32'h200, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0), C_JUMP, 32'h200);
        step("jd_halted", idle, C_HALT, 32'h0);
        step("jd_resume", idle, C_NONE, 32'h0);
        step("jd_run2", idle, C_NONE, 32'h0);

        // ex busy during DRAIN freezes the drain counter for that cycle.
        step("bd_run", hlt, C_NONE, 32'h0);
        step("bd_drain_busy", mk(0, 32'h0, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0), C_BUSY, 32'h0);
        step("bd_drain_still", idle, C_STALL, 32'h0);
        step("bd_halted", idle, C_HALT, 32'h0);
        step("bd_resume", idle, C_NONE, 32'h0);
        step("bd_run2", idle, C_NONE, 32'h0);

        // Reset while HALTED returns to RUN on the next edge.
        step("rh_run", hlt, C_NONE, 32'h0);
        step("rh_drain", hlt, C_STALL, 32'h0);
        step("rh_halted", hlt, C_HALT, 32'h0);
        rst = 1'b1;
        step("rh_rst", hlt, C_ACK, 32'h0);
        rst = 1'b0;
        step("rh_after_run", hlt, C_NONE, 32'h0);
        step("rh_after_drain", idle, C_STALL, 32'h0);
        step("rh_after_halted", idle, C_HALT, 32'h0);
        step("rh_after_resume", idle, C_NONE, 32'h0);
        step("rh_after_idle", idle, C_NONE, 32'h0);

`ifdef PIPE_CTRL_PERF_EN
        check("stall_cnt", bus.stall_cnt_o, 32'(stall_model));
        check("flush_cnt", bus.flush_cnt_o, 32'(flush_model));
`else
        check("stall_cnt", bus.stall_cnt_o, 32'h0);
        check("flush_cnt", bus.flush_cnt_o, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
